// File: rtl/dwt_pkg.sv
// Shared types and geometry helpers for the multi-level 2D DWT scheduler.
package dwt_pkg;

    localparam int unsigned DATA_WIDTH = 32'd16;
    localparam int unsigned SIDE_SIZE  = 32'd8;
    localparam int unsigned LEVELS     = 32'd3;

    typedef logic [2*DATA_WIDTH-1:0] coeff_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FEED_IN = 2'd1,
        ST_FEED_LL = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_e;

    // Beats per line: each beat carries an {odd, even} pair, so half the side.
    function automatic int unsigned line_len(input int unsigned side, input int unsigned level);
        return (side >> 32'd1) >> level;
    endfunction

    function automatic int unsigned rows(input int unsigned side, input int unsigned level);
        return side >> level;
    endfunction

    function automatic int unsigned clamp_levels(input int unsigned cfg, input int unsigned max_levels);
        if (cfg == 32'd0) begin
            return 32'd1;
        end else if (cfg > max_levels) begin
            return max_levels;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/dwt_frame_counter.sv
// Column/row beat counters for one DWT level frame; geometry follows the level.
module dwt_frame_counter
    import dwt_pkg::*;
#(
    parameter int unsigned SideSize = SIDE_SIZE,
    parameter int unsigned Levels   = LEVELS,
    localparam int unsigned LvlW    = (Levels > 32'd1) ? $clog2(Levels) : 32'd1,
    localparam int unsigned CntW    = $clog2(SideSize)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_beat,
    input  logic [LvlW-1:0] i_level,
    output logic            o_sof,
    output logic            o_eol,
    output logic            o_last_beat
);

    logic [CntW-1:0] r_col;
    logic [CntW-1:0] r_row;
    logic [CntW-1:0] w_col_max;
    logic [CntW-1:0] w_row_max;
    logic            w_line_last;

    assign w_col_max   = CntW'(line_len(SideSize, 32'(i_level)) - 32'd1);
    assign w_row_max   = CntW'(rows(SideSize, 32'(i_level)) - 32'd1);
    assign w_line_last = (r_col == w_col_max);

    assign o_sof       = (r_col == '0) && (r_row == '0);
    assign o_eol       = w_line_last;
    assign o_last_beat = w_line_last && (r_row == w_row_max);

    // Counters move only on accepted beats and clear on the frame's last beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_beat) begin
            if (o_last_beat) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_line_last) begin
                r_col <= '0;
                r_row <= r_row + CntW'(1'b1);
            end else begin
                r_col <= r_col + CntW'(1'b1);
                r_row <= r_row;
            end
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

endmodule

// File: rtl/dwt_level_scheduler.sv
// Level sequencer for the 2D DWT: selects tile input or LL feedback and frames each level.
module dwt_level_scheduler
    import dwt_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_WIDTH,
    parameter int unsigned SideSize  = SIDE_SIZE,
    parameter int unsigned Levels    = LEVELS,
    localparam int unsigned CfgW     = $clog2(Levels + 32'd1),
    localparam int unsigned LvlW     = (Levels > 32'd1) ? $clog2(Levels) : 32'd1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [CfgW-1:0]        cfg_levels_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   fb_valid_i,
    output logic                   fb_ready_o,
    input  logic [2*DataWidth-1:0] fb_data_i,
    input  logic                   d_ready_i,
    output logic                   d_valid_o,
    output logic                   d_sof_o,
    output logic                   d_eol_o,
    output logic [2*DataWidth-1:0] d_data_o,
    output logic [LvlW-1:0]        level_o,
    output logic                   busy_o,
    output logic                   done_o
);

    sched_state_e    r_state;
    sched_state_e    w_state_nxt;
    logic [CfgW-1:0] r_levels;
    logic [CfgW-1:0] w_levels_nxt;
    logic [LvlW-1:0] r_level;
    logic [LvlW-1:0] w_level_nxt;
    logic [CfgW-1:0] w_cfg_clamped;
    logic            w_beat;
    logic            w_sof;
    logic            w_eol;
    logic            w_last_beat;

    assign w_cfg_clamped = CfgW'(clamp_levels(32'(cfg_levels_i), Levels));
    assign w_beat        = d_valid_o & d_ready_i;

    dwt_frame_counter #(
        .SideSize (SideSize),
        .Levels   (Levels)
    ) u_frame_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_beat      (w_beat),
        .i_level     (r_level),
        .o_sof       (w_sof),
        .o_eol       (w_eol),
        .o_last_beat (w_last_beat)
    );

    assign d_sof_o = d_valid_o & w_sof;
    assign d_eol_o = d_valid_o & w_eol;
    assign level_o = r_level;
    assign busy_o  = (r_state != ST_IDLE);

    // State, latched level count and current level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_levels <= '0;
            r_level  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_levels <= w_levels_nxt;
            r_level  <= w_level_nxt;
        end
    end

    // Next state and the combinational source multiplexer.
    always_comb begin
        w_state_nxt  = r_state;
        w_levels_nxt = r_levels;
        w_level_nxt  = r_level;
        d_valid_o    = 1'b0;
        d_data_o     = '0;
        s_ready_o    = 1'b0;
        fb_ready_o   = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Bubble cycle: config is latched here, nothing transfers.
                if (s_valid_i) begin
                    w_state_nxt  = ST_FEED_IN;
                    w_levels_nxt = w_cfg_clamped;
                    w_level_nxt  = '0;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_FEED_IN: begin
                d_valid_o = s_valid_i;
                s_ready_o = d_ready_i;
                d_data_o  = s_valid_i ? s_data_i : '0;
                if (w_beat && w_last_beat) begin
                    if (32'(r_levels) > 32'd1) begin
                        w_state_nxt = ST_FEED_LL;
                        w_level_nxt = LvlW'(1'b1);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_FEED_IN;
                end
            end
            ST_FEED_LL: begin
                d_valid_o  = fb_valid_i;
                fb_ready_o = d_ready_i;
                d_data_o   = fb_valid_i ? fb_data_i : '0;
                if (w_beat && w_last_beat) begin
                    if ((32'(r_level) + 32'd1) < 32'(r_levels)) begin
                        w_state_nxt = ST_FEED_LL;
                        w_level_nxt = r_level + LvlW'(1'b1);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_FEED_LL;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dwt_level_scheduler.sv
// Directed self-checking bench for dwt_level_scheduler (Levels=3, SideSize=8).
module tb_dwt_level_scheduler;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  cfg_levels_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_data_i;
    logic        fb_valid_i;
    logic        fb_ready_o;
    logic [31:0] fb_data_i;
    logic        d_ready_i;
    logic        d_valid_o;
    logic        d_sof_o;
    logic        d_eol_o;
    logic [31:0] d_data_o;
    logic [1:0]  level_o;
    logic        busy_o;
    logic        done_o;

    int n_checks;
    int n_errors;

    dwt_level_scheduler dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_levels_i (cfg_levels_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .fb_valid_i   (fb_valid_i),
        .fb_ready_o   (fb_ready_o),
        .fb_data_i    (fb_data_i),
        .d_ready_i    (d_ready_i),
        .d_valid_o    (d_valid_o),
        .d_sof_o      (d_sof_o),
        .d_eol_o      (d_eol_o),
        .d_data_o     (d_data_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] s_pat(input int i);
        return 32'h5000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] fb_pat(input int i);
        return 32'hF000_0000 + 32'(i);
    endfunction

    // Presents the tile's first beat and checks the IDLE bubble cycle.
    task automatic start_tile(input logic [1:0] cfg);
        cfg_levels_i = cfg;
        s_valid_i    = 1'b1;
        s_data_i     = s_pat(0);
        fb_valid_i   = 1'b0;
        d_ready_i    = 1'b1;
        @(negedge clk_i);
        check_eq("bubble_valid", 64'(d_valid_o), 64'd0);
        check_eq("bubble_sready", 64'(s_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Streams n beats from the selected source with the other source also asserting valid.
    task automatic feed(input bit from_fb, input int n, input int ll, input int lvl);
        for (int i = 0; i < n; i++) begin
            d_ready_i  = 1'b1;
            s_valid_i  = 1'b1;
            fb_valid_i = 1'b1;
            s_data_i   = from_fb ? 32'hDEAD_BEEF : s_pat(i);
            fb_data_i  = from_fb ? fb_pat(i) : 32'hDEAD_BEEF;
            @(negedge clk_i);
            check_eq("valid", 64'(d_valid_o), 64'd1);
            check_eq("data", 64'(d_data_o), from_fb ? 64'(fb_pat(i)) : 64'(s_pat(i)));
            check_eq("sof", 64'(d_sof_o), (i == 0) ? 64'd1 : 64'd0);
            check_eq("eol", 64'(d_eol_o), ((i % ll) == (ll - 1)) ? 64'd1 : 64'd0);
            check_eq("level", 64'(level_o), 64'(lvl));
            check_eq("s_ready", 64'(s_ready_o), from_fb ? 64'd0 : 64'd1);
            check_eq("fb_ready", 64'(fb_ready_o), from_fb ? 64'd1 : 64'd0);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_done();
        s_valid_i  = 1'b0;
        fb_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("done_pulse", 64'(done_o), 64'd1);
        check_eq("done_busy", 64'(busy_o), 64'd1);
        check_eq("done_valid", 64'(d_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check_eq("done_clear", 64'(done_o), 64'd0);
        check_eq("idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Random valid/ready traffic over a two-level tile, scoreboarded against the source order.
    task automatic stress();
        int si;
        int fi;
        int k;
        int cyc;
        bit s_hold;
        bit fb_hold;
        bit stalled;
        logic [31:0] exp_data;
        logic p_sof;
        logic p_eol;
        logic [31:0] p_data;
        si = 0; fi = 0; k = 0; cyc = 0;
        s_hold = 1'b0; fb_hold = 1'b0; stalled = 1'b0;
        p_sof = 1'b0; p_eol = 1'b0; p_data = '0;
        cfg_levels_i = 2'd2;
        while (k < 40 && cyc < 2000) begin
            s_valid_i  = (si < 32) && (s_hold || ($urandom_range(1, 0) == 1));
            fb_valid_i = (fi < 8) && (fb_hold || ($urandom_range(1, 0) == 1));
            s_data_i   = s_pat(si);
            fb_data_i  = fb_pat(fi);
            d_ready_i  = ($urandom_range(1, 0) == 1);
            @(negedge clk_i);
            if (stalled && d_valid_o) begin
                check_eq("stall_sof", 64'(d_sof_o), 64'(p_sof));
                check_eq("stall_eol", 64'(d_eol_o), 64'(p_eol));
                check_eq("stall_data", 64'(d_data_o), 64'(p_data));
            end
            stalled = d_valid_o && !d_ready_i;
            p_sof = d_sof_o; p_eol = d_eol_o; p_data = d_data_o;
            if (d_valid_o && d_ready_i) begin
                exp_data = (k < 32) ? s_pat(k) : fb_pat(k - 32);
                check_eq("rnd_data", 64'(d_data_o), 64'(exp_data));
                check_eq("rnd_sof", 64'(d_sof_o), (k == 0 || k == 32) ? 64'd1 : 64'd0);
                check_eq("rnd_eol", 64'(d_eol_o),
                         (k < 32) ? (((k % 4) == 3) ? 64'd1 : 64'd0) : (((k % 2) == 1) ? 64'd1 : 64'd0));
                k++;
            end
            s_hold  = s_valid_i && !s_ready_o;
            fb_hold = fb_valid_i && !fb_ready_o;
            if (s_valid_i && s_ready_o) si++;
            if (fb_valid_i && fb_ready_o) fi++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check_eq("rnd_beats", 64'(k), 64'd40);
        check_eq("rnd_fb_used", 64'(fi), 64'd8);
        check_done();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_ni = 1'b0;
        cfg_levels_i = 2'd1;
        s_valid_i = 1'b0; s_data_i = '0;
        fb_valid_i = 1'b0; fb_data_i = '0;
        d_ready_i = 1'b0;
        #12;
        check_eq("rst_valid", 64'(d_valid_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_level", 64'(level_o), 64'd0);
        check_eq("rst_readies", 64'({s_ready_o, fb_ready_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // T1: single level
        start_tile(2'd1);
        feed(1'b0, 32, 4, 0);
        check_done();

        // T2/T4: full three-level tile with the idle source asserting valid
        start_tile(2'd3);
        cfg_levels_i = 2'd1;
        feed(1'b0, 32, 4, 0);
        feed(1'b1, 8, 2, 1);
        feed(1'b1, 2, 1, 2);
        check_done();

        // T5: zero request behaves as a single level
        start_tile(2'd0);
        feed(1'b0, 32, 4, 0);
        check_done();

        // T3: random stalls
        stress();

        // T6: reset at row 3 of level 1
        start_tile(2'd2);
        feed(1'b0, 32, 4, 0);
        feed(1'b1, 6, 2, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", 64'(d_valid_o), 64'd0);
        check_eq("arst_framing", 64'({d_sof_o, d_eol_o}), 64'd0);
        check_eq("arst_readies", 64'({s_ready_o, fb_ready_o}), 64'd0);
        check_eq("arst_busy", 64'(busy_o), 64'd0);
        check_eq("arst_level", 64'(level_o), 64'd0);
        check_eq("arst_data", 64'(d_data_o), 64'd0);
        s_valid_i  = 1'b0;
        fb_valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        start_tile(2'd1);
        feed(1'b0, 32, 4, 0);
        check_done();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
